// File: rtl/seg7_scan_driver_if.sv
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Bundle between the display formatter (master) and the
//               multiplexed 7-segment scan driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] din;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_done;

  modport master (
    output din, dp_in, load, blank_en,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  din, dp_in, load, blank_en,
    output seg, dp, dig_sel, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed DIGITS-wide 7-segment driver. Hex decode,
//               time-multiplexed scanning with a blank guard slot at the start
//               of each digit, double-buffered loading applied only at frame
//               boundaries, leading-zero blanking and selectable pin polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter bit DIG_ACT_HIGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRESC_W-1:0] c_PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   c_IDX_LAST   = IDX_W'(DIGITS - 1);

  // Pin levels that mean "unlit" / "digit disabled" for the chosen polarity.
  localparam logic [6:0]        c_SEG_OFF = {7{~SEG_ACT_HIGH}};
  localparam logic              c_DP_OFF  = ~SEG_ACT_HIGH;
  localparam logic [DIGITS-1:0] c_DIG_OFF = {DIGITS{~DIG_ACT_HIGH}};

  // Scan position
  logic [PRESC_W-1:0]  r_presc;
  logic [IDX_W-1:0]    r_idx;

  // Double buffer: active is what is on the glass, pending waits for a boundary
  logic [4*DIGITS-1:0] r_act_din;
  logic [DIGITS-1:0]   r_act_dp;
  logic [4*DIGITS-1:0] r_pend_din;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_valid;

  // Registered pin drivers
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_dig_sel;
  logic                r_frame_done;

  logic                w_presc_wrap;
  logic                w_frame_end;
  logic [3:0]          w_cur_nib;
  logic                w_cur_dp;
  logic                w_cur_tail;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_tail_zero;
  logic                w_run;
  logic                w_blank;
  logic [6:0]          w_seg_lit;
  logic                w_dp_lit;
  logic [DIGITS-1:0]   w_dig_en;

  // Active-high gfedcba glyph for one hex nibble.
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign w_presc_wrap = (r_presc == c_PRESC_LAST);
  assign w_frame_end  = w_presc_wrap && (r_idx == c_IDX_LAST);

  // Prescaler and digit index; the index only moves when the prescaler wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_presc_wrap) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Buffer update: a load on the boundary edge bypasses pending so it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_din    <= '0;
      r_act_dp     <= '0;
      r_pend_din   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_frame_end) begin
      if (bus.load) begin
        r_act_din <= bus.din;
        r_act_dp  <= bus.dp_in;
      end else if (r_pend_valid) begin
        r_act_din <= r_pend_din;
        r_act_dp  <= r_pend_dp;
      end
      r_pend_valid <= 1'b0;
    end else if (bus.load) begin
      r_pend_din   <= bus.din;
      r_pend_dp    <= bus.dp_in;
      r_pend_valid <= 1'b1;
    end
  end

  // Digit selection and leading-zero detection, scanning from the MSD down.
  always_comb begin
    w_tail_zero = '0;
    w_run       = 1'b1;
    w_cur_nib   = 4'h0;
    w_cur_dp    = 1'b0;
    w_cur_tail  = 1'b0;
    w_onehot    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run & (r_act_din[4*i +: 4] == 4'h0) & ~r_act_dp[i];
      w_tail_zero[i] = w_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_nib   = r_act_din[4*i +: 4];
        w_cur_dp    = r_act_dp[i];
        w_cur_tail  = w_tail_zero[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Logical (active-high) pin values; prescaler slot 0 is the anti-ghost gap.
  always_comb begin
    w_seg_lit = 7'h00;
    w_dp_lit  = 1'b0;
    w_dig_en  = '0;
    w_blank   = bus.blank_en && (r_idx != '0) && w_cur_tail;
    if (r_presc != '0) begin
      w_dig_en = w_onehot;
      if (!w_blank) begin
        w_seg_lit = f_glyph(w_cur_nib);
        w_dp_lit  = w_cur_dp;
      end
    end
  end

  // Output register applies pin polarity and times the frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg        <= c_SEG_OFF;
      r_dp         <= c_DP_OFF;
      r_dig_sel    <= c_DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= SEG_ACT_HIGH ? w_seg_lit : ~w_seg_lit;
      r_dp         <= SEG_ACT_HIGH ? w_dp_lit  : ~w_dp_lit;
      r_dig_sel    <= DIG_ACT_HIGH ? w_dig_en  : ~w_dig_en;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig_sel    = r_dig_sel;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               DIGITS=4, SCAN_DIV=4, active-high segments, active-low digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  int   total = 0;
  int   bad   = 0;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) bus_if ();

  seg7_scan_driver #(
    .DIGITS      (4),
    .SCAN_DIV    (4),
    .SEG_ACT_HIGH(1'b1),
    .DIG_ACT_HIGH(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Observed pins packed as {dig_sel, seg, dp, frame_done}.
  wire [12:0] w_obs = {bus_if.dig_sel, bus_if.seg, bus_if.dp, bus_if.frame_done};

  localparam logic [12:0] c_RESET_PINS = {4'b1111, 7'h00, 1'b0, 1'b0};

  // Expected pins at position j (1..16) after a frame_done sample.
  // segs = {s3,s2,s1,s0} as displayed glyphs, dps = per-digit dp.
  function automatic logic [12:0] f_expect(input int j, input logic [27:0] segs,
                                           input logic [3:0] dps);
    int         slot;
    int         ph;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] one;
    slot = (j - 1) / 4;
    ph   = (j - 1) % 4;
    one  = 4'b0001 << slot;
    if (ph == 0) begin
      e_dig = 4'b1111;
      e_seg = 7'h00;
      e_dp  = 1'b0;
    end else begin
      e_dig = ~one;
      e_seg = segs[slot*7 +: 7];
      e_dp  = dps[slot];
    end
    return {e_dig, e_seg, e_dp, (j == 16)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] p);
    bus_if.din   = d;
    bus_if.dp_in = p;
    bus_if.load  = 1'b1;
    step();
    bus_if.load  = 1'b0;
  endtask

  // Advance to the next sample with frame_done high, bounded.
  task automatic sync_frame(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus_if.frame_done !== 1'b1 && n < 40);
    if (bus_if.frame_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s frame_done timeout got=%b want=1", name, bus_if.frame_done);
    end
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (w_obs !== c_RESET_PINS) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%h want=%h", k, w_obs, c_RESET_PINS);
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      e = f_expect(j, {4{7'h3F}}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL reset_release j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
  endtask

  task automatic test_scan_guard();
    logic [12:0] e;
    drive_load(16'h12AF, 4'b0000);
    sync_frame("scan_sync");
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 16; j++) begin
        step();
        e = f_expect(j, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000);
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL scan f=%0d j=%0d got=%h want=%h", f, j, w_obs, e);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    logic [12:0] e;
    for (int k = 0; k < 4; k++) step();
    drive_load(16'h1111, 4'b0000);
    for (int j = 6; j <= 16; j++) begin
      step();
      e = f_expect(j, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL dbuf_old j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      step();
      e = f_expect(j, {4{7'h06}}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL dbuf_new j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
    step();
    step();
    drive_load(16'h2222, 4'b0000);
    for (int k = 0; k < 5; k++) step();
    drive_load(16'h3333, 4'b0000);
    for (int j = 10; j <= 16; j++) begin
      step();
      e = f_expect(j, {4{7'h06}}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL dbuf_hold j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 16; j++) begin
        step();
        e = f_expect(j, {4{7'h4F}}, 4'b0000);
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL dbuf_last f=%0d j=%0d got=%h want=%h", f, j, w_obs, e);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [12:0] e;
    step();
    drive_load(16'h5555, 4'b0000);
    for (int k = 0; k < 13; k++) step();
    drive_load(16'h4444, 4'b0000);
    total++;
    if (bus_if.frame_done !== 1'b1) begin
      bad++;
      $display("FAIL collide_edge frame_done got=%b want=1", bus_if.frame_done);
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 16; j++) begin
        step();
        e = f_expect(j, {4{7'h66}}, 4'b0000);
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL collide f=%0d j=%0d got=%h want=%h", f, j, w_obs, e);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] d_tab   [4] = '{16'h0050, 16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  p_tab   [4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic        b_tab   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [27:0] s_tab   [4] = '{{7'h00, 7'h00, 7'h6D, 7'h3F},
                                 {7'h00, 7'h00, 7'h00, 7'h3F},
                                 {7'h00, 7'h3F, 7'h3F, 7'h3F},
                                 {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    logic [12:0] e;
    for (int v = 0; v < 4; v++) begin
      bus_if.blank_en = 1'b1;
      drive_load(d_tab[v], p_tab[v]);
      sync_frame("blank_sync");
      bus_if.blank_en = b_tab[v];
      for (int j = 1; j <= 16; j++) begin
        step();
        e = f_expect(j, s_tab[v], p_tab[v]);
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL blank v=%0d j=%0d got=%h want=%h", v, j, w_obs, e);
        end
      end
    end
    bus_if.blank_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    drive_load(16'h9876, 4'b0000);
    sync_frame("rmid_sync");
    for (int j = 1; j <= 10; j++) begin
      step();
      e = f_expect(j, {7'h6F, 7'h7F, 7'h07, 7'h7D}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL rmid_pre j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
    rst_n = 1'b0;
    step();
    total++;
    if (w_obs !== c_RESET_PINS) begin
      bad++;
      $display("FAIL rmid_reset got=%h want=%h", w_obs, c_RESET_PINS);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      e = f_expect(j, {4{7'h3F}}, 4'b0000);
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL rmid_post j=%0d got=%h want=%h", j, w_obs, e);
      end
    end
  endtask

  initial begin
    bus_if.din      = 16'h0000;
    bus_if.dp_in    = 4'b0000;
    bus_if.load     = 1'b0;
    bus_if.blank_en = 1'b0;
    test_reset();
    test_scan_guard();
    test_double_buffer();
    test_collision();
    test_blanking();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
